nibble_serial_adder: RTL and testbench

Multi-word adder/subtractor built around a 4-bit add slice with carry-in. It accepts two W-bit operands through a valid/ready handshake and processes them one nibble per cycle, least-significant first, carrying between nibbles in a register. It then presents the W-bit result, carry and signed overflow through a valid/ready output handshake. It is the sequencing stage that feeds the team's 4-bit ripple datapath and consumes its sum and carry, so wide operands can be handled without widening the adder.

---
 rtl/nibble_serial_adder.sv | 133 +++++++++++++
 tb/tb_nibble_serial_adder.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Sequential W-bit adder/subtractor: operands are captured once, then summed one
// 4-bit slice per cycle (LSB first) with the carry held in a register between slices.
module nibble_serial_adder #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   input  logic                 sub,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 carry_out,
   output logic                 overflow
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    sum_q, sum_d;
   logic            carry_out_q, carry_out_d;
   logic            overflow_q, overflow_d;

   logic [3:0]      a_nib_s;
   logic [3:0]      b_nib_s;
   logic [3:0]      low_s;
   logic [4:0]      full_s;

   // Active 4-bit slice; low_s[3] is the carry into the slice MSB, needed for overflow.
   always_comb begin
      a_nib_s = a_q[{idx_q, 2'b00} +: 4];
      b_nib_s = b_q[{idx_q, 2'b00} +: 4];
      low_s   = {1'b0, a_nib_s[2:0]} + {1'b0, b_nib_s[2:0]} + {3'b000, carry_q};
      full_s  = {1'b0, a_nib_s} + {1'b0, b_nib_s} + {4'b0000, carry_q};
   end

   // Next-state and datapath update for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      sum_d       = sum_q;
      carry_out_d = carry_out_q;
      overflow_d  = overflow_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in.
               if (sub) begin
                  b_d = ~b;
               end else begin
                  b_d = b;
               end
               carry_d = sub;
               idx_d   = {IW{1'b0}};
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d[{idx_q, 2'b00} +: 4] = full_s[3:0];
            carry_d                    = full_s[4];
            if (idx_q == LAST_IDX) begin
               carry_out_d = full_s[4];
               overflow_d  = low_s[3] ^ full_s[4];
               idx_d       = {IW{1'b0}};
               state_d     = DONE;
            end else begin
               idx_d       = idx_q + IW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= {IW{1'b0}};
         carry_q     <= 1'b0;
         a_q         <= {W{1'b0}};
         b_q         <= {W{1'b0}};
         sum_q       <= {W{1'b0}};
         carry_out_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         sum_q       <= sum_d;
         carry_out_q <= carry_out_d;
         overflow_q  <= overflow_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign sum       = sum_q;
   assign carry_out = carry_out_q;
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (NIBBLES=4): directed vectors,
// backpressure/isolation, async reset mid-op, back-to-back and random ops.
module tb_nibble_serial_adder;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        sub;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] sum;
   logic        carry_out;
   logic        overflow;

   int tests = 0;
   int fails = 0;

   nibble_serial_adder #(.NIBBLES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .carry_out(carry_out), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, returns {overflow, carry_out, sum}.
   function automatic logic [17:0] model(input logic [15:0] ta, input logic [15:0] tb_, input logic ts);
      int          sa, sb, r;
      int unsigned ua, ub;
      logic        co, ov;
      logic [15:0] s;
      sa = int'($signed(ta));
      sb = int'($signed(tb_));
      ua = int'(ta);
      ub = int'(tb_);
      if (ts) begin
         r  = sa - sb;
         co = (ua >= ub);
      end else begin
         r  = sa + sb;
         co = ((ua + ub) > 65535);
      end
      ov = (r > 32767) || (r < -32768);
      s  = r[15:0];
      return {ov, co, s};
   endfunction

   // Drive one op: wait for in_ready, accept, then wait (bounded) for out_valid.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                        output int lat, output time t_acc);
      int guard = 0;
      in_valid = 1'b1; a = ta; b = tb_; sub = ts;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1; guard++;
      end
      @(posedge clk);
      t_acc = $time;
      #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000; sub = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      tests++;
      if ({in_ready, out_valid, sum, carry_out, overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_state got rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 0000 0 0",
                  in_ready, out_valid, sum, carry_out, overflow);
      end
   endtask

   task automatic test_directed();
      logic [15:0] va [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
      logic [15:0] vb [5] = '{16'h4321, 16'h0001, 16'h0001, 16'h0007, 16'h0001};
      logic        vs [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic [17:0] req [5] = '{{1'b0, 1'b0, 16'h5555}, {1'b0, 1'b1, 16'h0000},
                               {1'b1, 1'b0, 16'h8000}, {1'b0, 1'b0, 16'hFFFE},
                               {1'b1, 1'b1, 16'h7FFF}};
      int  lat;
      time t;
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         do_op(va[i], vb[i], vs[i], lat, t);
         tests++;
         if (lat !== 4) begin
            fails++; $display("FAIL directed_latency[%0d] got %0d want 4", i, lat);
         end
         tests++;
         if ({overflow, carry_out, sum} !== req[i]) begin
            fails++;
            $display("FAIL directed[%0d] got ov=%b co=%b sum=%h want ov=%b co=%b sum=%h",
                     i, overflow, carry_out, sum, req[i][17], req[i][16], req[i][15:0]);
         end
         @(posedge clk); #1;
         tests++;
         if ({in_ready, out_valid} !== 2'b10) begin
            fails++; $display("FAIL directed_handshake[%0d] got rdy=%b vld=%b want 1 0", i, in_ready, out_valid);
         end
      end
   endtask

   task automatic test_backpressure();
      int          lat;
      time         t;
      logic [17:0] held;
      out_ready = 1'b0;
      do_op(16'h0F0F, 16'h7123, 1'b1, lat, t);
      held = model(16'h0F0F, 16'h7123, 1'b1);
      tests++;
      if ({overflow, carry_out, sum} !== held) begin
         fails++; $display("FAIL bp_result got %h want %h", {overflow, carry_out, sum}, held);
      end
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
         @(posedge clk); #1;
         tests++;
         if ({in_ready, out_valid, overflow, carry_out, sum} !== {2'b01, held}) begin
            fails++;
            $display("FAIL bp_hold[%0d] got rdy=%b vld=%b res=%h want 0 1 %h",
                     i, in_ready, out_valid, {overflow, carry_out, sum}, held);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
         fails++; $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL bp_no_accept got rdy=%b want 1", in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int  lat;
      time t;
      out_ready = 1'b1;
      in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0;
      @(posedge clk); #1;            // accept edge
      in_valid = 1'b0;
      @(posedge clk); #2;            // inside the 2nd RUN cycle
      rst = 1'b1;
      #1;
      tests++;
      if ({in_ready, out_valid, sum, carry_out, overflow} !== {1'b1, 1'b0, 16'h0000, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_mid got rdy=%b vld=%b sum=%h co=%b ov=%b want 1 0 0000 0 0",
                  in_ready, out_valid, sum, carry_out, overflow);
      end
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      do_op(16'h0001, 16'h0001, 1'b0, lat, t);
      tests++;
      if (lat !== 4 || sum !== 16'h0002 || carry_out !== 1'b0 || overflow !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_followup got lat=%0d sum=%h co=%b ov=%b want 4 0002 0 0",
                  lat, sum, carry_out, overflow);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int          lat;
      time         t, t_prev;
      logic [15:0] ta, tb_;
      logic        ts;
      logic [17:0] exp_r;
      out_ready = 1'b1;
      t_prev = 0;
      for (int i = 0; i < 4; i++) begin
         ta = 16'($urandom); tb_ = 16'($urandom); ts = 1'($urandom);
         exp_r = model(ta, tb_, ts);
         do_op(ta, tb_, ts, lat, t);
         tests++;
         if ({overflow, carry_out, sum} !== exp_r) begin
            fails++; $display("FAIL b2b_result[%0d] got %h want %h", i, {overflow, carry_out, sum}, exp_r);
         end
         if (i > 0) begin
            tests++;
            if (t - t_prev !== 60) begin
               fails++; $display("FAIL b2b_spacing[%0d] got %0t want 60", i, t - t_prev);
            end
         end
         t_prev = t;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      int          lat;
      time         t;
      logic [15:0] ta, tb_;
      logic        ts;
      logic [17:0] exp_r;
      for (int i = 0; i < 40; i++) begin
         ta = 16'($urandom); tb_ = 16'($urandom); ts = 1'($urandom);
         if (i % 8 == 0) tb_ = ta;
         exp_r = model(ta, tb_, ts);
         out_ready = 1'b0;
         do_op(ta, tb_, ts, lat, t);
         repeat ($urandom_range(0, 3)) begin
            @(posedge clk); #1;
         end
         tests++;
         if (lat !== 4 || {overflow, carry_out, sum} !== exp_r) begin
            fails++;
            $display("FAIL random[%0d] a=%h b=%h sub=%b got lat=%0d res=%h want 4 %h",
                     i, ta, tb_, ts, lat, {overflow, carry_out, sum}, exp_r);
         end
         out_ready = 1'b1;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
